// File: rtl/operand_entry_buf_if.sv
// Keypad-side bundle for operand_entry_buf: key strobe/code and calculator context in,
// live entry, digit count and committed value out.
interface operand_entry_buf_if #(
   parameter int N_DIGITS = 4
);
   localparam int W  = 4 * N_DIGITS;
   localparam int NW = $clog2(N_DIGITS + 1);

   // bc is a single-cycle strobe with no back-pressure: every cycle with bc=1 is one key
   // press and the buffer always consumes it; guardar/reject answer it one cycle later.
   logic          bc;
   logic [4:0]    val;
   logic [2:0]    calcstate;
   logic          dec_mode;
   logic [W-1:0]  op;
   logic [NW-1:0] ndig;
   logic          full;
   logic          guardar;
   logic [W-1:0]  op_saved;
   logic          is_oper;
   logic          reject;

   modport master (
      output bc, val, calcstate, dec_mode,
      input  op, ndig, full, guardar, op_saved, is_oper, reject
   );

   modport slave (
      input  bc, val, calcstate, dec_mode,
      output op, ndig, full, guardar, op_saved, is_oper, reject
   );
endinterface

// File: rtl/operand_entry_buf.sv
// Keypad operand/operator entry buffer: shifts digits into a live operand, loads operator
// codes, supports backspace/clear, and commits to a holding register on ENTER.
module operand_entry_buf #(
   parameter int         N_DIGITS   = 4,
   parameter logic [4:0] ENTER_CODE = 5'h13,
   parameter logic [4:0] BKSP_CODE  = 5'h14,
   parameter logic [4:0] CLR_CODE   = 5'h15,
   parameter logic [2:0] OP_STATE   = 3'b010,
   parameter logic [2:0] LOCK_STATE = 3'b011
) (
   input logic               clk,
   input logic               reset,
   operand_entry_buf_if.slave bus
);
   localparam int W  = 4 * N_DIGITS;
   localparam int NW = $clog2(N_DIGITS + 1);

   logic [W-1:0]  op_q, op_d;
   logic [NW-1:0] ndig_q, ndig_d;
   logic [W-1:0]  op_saved_q, op_saved_d;
   logic          is_oper_q, is_oper_d;
   logic          guardar_q, guardar_d;
   logic          reject_q, reject_d;
   logic          pend_q, pend_d;
   logic          full_w;
   logic          is_ctl;

   assign full_w = (ndig_q == NW'(N_DIGITS));
   assign is_ctl = bus.val[4];

   always_comb begin
      op_d       = op_q;
      ndig_d     = ndig_q;
      op_saved_d = op_saved_q;
      is_oper_d  = is_oper_q;
      pend_d     = pend_q;
      guardar_d  = 1'b0;
      reject_d   = 1'b0;
      if (bus.bc) begin
         if (bus.calcstate == LOCK_STATE) begin
            reject_d = 1'b1;
         end else if (bus.calcstate == OP_STATE) begin
            if (!is_ctl || bus.val == BKSP_CODE) begin
               reject_d = 1'b1;
            end else if (bus.val == CLR_CODE) begin
               op_d   = '0;
               ndig_d = '0;
               pend_d = 1'b0;
            end else if (bus.val == ENTER_CODE) begin
               if (pend_q) begin
                  op_saved_d = op_q;
                  is_oper_d  = 1'b1;
                  guardar_d  = 1'b1;
                  op_d       = '0;
                  ndig_d     = '0;
                  pend_d     = 1'b0;
               end else begin
                  reject_d = 1'b1;
               end
            end else begin
               // Operator replaces whatever is displayed; a later operator overwrites it.
               op_d   = W'(bus.val);
               ndig_d = '0;
               pend_d = 1'b1;
            end
         end else begin
            if (!is_ctl) begin
               if (!full_w && !(bus.dec_mode && bus.val[3:0] > 4'd9)) begin
                  op_d   = (op_q << 4) | W'(bus.val[3:0]);
                  ndig_d = ndig_q + NW'(1);
                  pend_d = 1'b0;
               end else begin
                  reject_d = 1'b1;
               end
            end else if (bus.val == BKSP_CODE) begin
               if (ndig_q != '0) begin
                  op_d   = op_q >> 4;
                  ndig_d = ndig_q - NW'(1);
               end else begin
                  reject_d = 1'b1;
               end
            end else if (bus.val == CLR_CODE) begin
               op_d   = '0;
               ndig_d = '0;
               pend_d = 1'b0;
            end else if (bus.val == ENTER_CODE) begin
               // An empty entry still commits, as the value 0.
               op_saved_d = op_q;
               is_oper_d  = 1'b0;
               guardar_d  = 1'b1;
               op_d       = '0;
               ndig_d     = '0;
               pend_d     = 1'b0;
            end else begin
               reject_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         op_q       <= '0;
         ndig_q     <= '0;
         op_saved_q <= '0;
         is_oper_q  <= 1'b0;
         guardar_q  <= 1'b0;
         reject_q   <= 1'b0;
         pend_q     <= 1'b0;
      end else begin
         op_q       <= op_d;
         ndig_q     <= ndig_d;
         op_saved_q <= op_saved_d;
         is_oper_q  <= is_oper_d;
         guardar_q  <= guardar_d;
         reject_q   <= reject_d;
         pend_q     <= pend_d;
      end
   end

   assign bus.op       = op_q;
   assign bus.ndig     = ndig_q;
   assign bus.full     = full_w;
   assign bus.guardar  = guardar_q;
   assign bus.op_saved = op_saved_q;
   assign bus.is_oper  = is_oper_q;
   assign bus.reject   = reject_q;
endmodule

// File: tb/tb_operand_entry_buf.sv
// Self-checking bench for operand_entry_buf: directed key sequences plus random back-to-back
// entry, with expected commits queued and matched against every guardar pulse.
module tb_operand_entry_buf;
   localparam int         N     = 4;
   localparam int         W     = 4 * N;
   localparam logic [4:0] ENTER = 5'h13;
   localparam logic [4:0] BKSP  = 5'h14;
   localparam logic [4:0] CLR   = 5'h15;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   // Expected commits: {is_oper, op_saved}
   logic [W:0] exp_q[$];

   operand_entry_buf_if #(.N_DIGITS(N)) bus ();

   operand_entry_buf #(.N_DIGITS(N)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Commit monitor: every guardar pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (bus.guardar === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL commit_unexpected: got is_oper=%0b op_saved=%h, expected no commit",
                     bus.is_oper, bus.op_saved);
         end else begin
            logic [W:0] e;
            e = exp_q.pop_front();
            if ({bus.is_oper, bus.op_saved} !== e) begin
               errors++;
               $display("FAIL commit_value: got is_oper=%0b op_saved=%h, expected is_oper=%0b op_saved=%h",
                        bus.is_oper, bus.op_saved, e[W], e[W-1:0]);
            end
         end
      end
   end

   task automatic press(input logic [4:0] v);
      @(negedge clk);
      bus.bc  = 1'b1;
      bus.val = v;
      @(negedge clk);
      bus.bc  = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      bus.bc = 1'b0; bus.val = '0; bus.calcstate = 3'b000; bus.dec_mode = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.op, bus.ndig, bus.full, bus.guardar, bus.op_saved, bus.is_oper, bus.reject} !== '0) begin
         errors++;
         $display("FAIL reset_state: got op=%h ndig=%0d full=%0b g=%0b saved=%h io=%0b rej=%0b, expected all 0",
                  bus.op, bus.ndig, bus.full, bus.guardar, bus.op_saved, bus.is_oper, bus.reject);
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_hex_entry;
      logic [4:0]   keys[4] = '{5'h1, 5'hA, 5'h2, 5'hF};
      logic [W-1:0] exp_op[4] = '{16'h0001, 16'h001A, 16'h01A2, 16'h1A2F};
      for (int i = 0; i < 4; i++) begin
         press(keys[i]);
         checks++;
         if (bus.op !== exp_op[i] || bus.ndig !== 3'(i + 1) || bus.reject !== 1'b0) begin
            errors++;
            $display("FAIL hex_digit%0d: got op=%h ndig=%0d rej=%0b, expected op=%h ndig=%0d rej=0",
                     i, bus.op, bus.ndig, bus.reject, exp_op[i], i + 1);
         end
      end
      checks++;
      if (bus.full !== 1'b1) begin
         errors++;
         $display("FAIL hex_full: got %0b, expected 1", bus.full);
      end
      exp_q.push_back({1'b0, 16'h1A2F});
      press(ENTER);
      checks++;
      if (bus.guardar !== 1'b1 || bus.op !== '0 || bus.ndig !== '0 || bus.is_oper !== 1'b0) begin
         errors++;
         $display("FAIL hex_enter: got g=%0b op=%h ndig=%0d io=%0b, expected g=1 op=0 ndig=0 io=0",
                  bus.guardar, bus.op, bus.ndig, bus.is_oper);
      end
      @(negedge clk);
      checks++;
      if (bus.guardar !== 1'b0 || bus.op_saved !== 16'h1A2F) begin
         errors++;
         $display("FAIL hex_pulse: got g=%0b saved=%h, expected g=0 saved=1a2f", bus.guardar, bus.op_saved);
      end
   endtask

   task automatic test_full_bksp;
      for (int i = 1; i <= 4; i++) press(5'(i));
      press(5'h5);
      checks++;
      if (bus.reject !== 1'b1 || bus.op !== 16'h1234 || bus.full !== 1'b1) begin
         errors++;
         $display("FAIL full_reject: got rej=%0b op=%h full=%0b, expected rej=1 op=1234 full=1",
                  bus.reject, bus.op, bus.full);
      end
      @(negedge clk);
      checks++;
      if (bus.reject !== 1'b0) begin
         errors++;
         $display("FAIL reject_pulse: got %0b, expected 0", bus.reject);
      end
      press(BKSP);
      checks++;
      if (bus.op !== 16'h0123 || bus.ndig !== 3'd3 || bus.full !== 1'b0) begin
         errors++;
         $display("FAIL bksp: got op=%h ndig=%0d full=%0b, expected op=0123 ndig=3 full=0",
                  bus.op, bus.ndig, bus.full);
      end
      press(CLR);
      press(BKSP);
      checks++;
      if (bus.reject !== 1'b1 || bus.ndig !== '0) begin
         errors++;
         $display("FAIL bksp_empty: got rej=%0b ndig=%0d, expected rej=1 ndig=0", bus.reject, bus.ndig);
      end
      press(5'h11);
      checks++;
      if (bus.reject !== 1'b1 || bus.op !== '0) begin
         errors++;
         $display("FAIL entry_bad_code: got rej=%0b op=%h, expected rej=1 op=0", bus.reject, bus.op);
      end
   endtask

   task automatic test_dec_mode;
      bus.dec_mode = 1'b1;
      press(5'h9);
      press(5'hB);
      checks++;
      if (bus.reject !== 1'b1 || bus.op !== 16'h0009) begin
         errors++;
         $display("FAIL dec_reject: got rej=%0b op=%h, expected rej=1 op=0009", bus.reject, bus.op);
      end
      press(5'h7);
      checks++;
      if (bus.op !== 16'h0097 || bus.ndig !== 3'd2) begin
         errors++;
         $display("FAIL dec_entry: got op=%h ndig=%0d, expected op=0097 ndig=2", bus.op, bus.ndig);
      end
      press(CLR);
      bus.dec_mode = 1'b0;
   endtask

   task automatic test_operator;
      bus.calcstate = 3'b010;
      press(5'h10);
      checks++;
      if (bus.op !== 16'h0010 || bus.ndig !== '0) begin
         errors++;
         $display("FAIL oper_load: got op=%h ndig=%0d, expected op=0010 ndig=0", bus.op, bus.ndig);
      end
      press(5'h12);
      exp_q.push_back({1'b1, 16'h0012});
      press(ENTER);
      checks++;
      if (bus.guardar !== 1'b1 || bus.is_oper !== 1'b1 || bus.op !== '0) begin
         errors++;
         $display("FAIL oper_enter: got g=%0b io=%0b op=%h, expected g=1 io=1 op=0",
                  bus.guardar, bus.is_oper, bus.op);
      end
      press(5'h5);
      checks++;
      if (bus.reject !== 1'b1 || bus.op !== '0) begin
         errors++;
         $display("FAIL oper_digit: got rej=%0b op=%h, expected rej=1 op=0", bus.reject, bus.op);
      end
      press(ENTER);
      checks++;
      if (bus.reject !== 1'b1 || bus.guardar !== 1'b0) begin
         errors++;
         $display("FAIL oper_enter_empty: got rej=%0b g=%0b, expected rej=1 g=0", bus.reject, bus.guardar);
      end
      bus.calcstate = 3'b000;
   endtask

   task automatic test_lock_clear;
      logic [4:0] lk[3] = '{5'h4, ENTER, CLR};
      press(5'h7); press(5'h8); press(5'h9);
      bus.calcstate = 3'b011;
      for (int i = 0; i < 3; i++) begin
         press(lk[i]);
         checks++;
         if (bus.reject !== 1'b1 || bus.op !== 16'h0789 || bus.ndig !== 3'd3 || bus.guardar !== 1'b0) begin
            errors++;
            $display("FAIL lock_key%0d: got rej=%0b op=%h ndig=%0d g=%0b, expected rej=1 op=0789 ndig=3 g=0",
                     i, bus.reject, bus.op, bus.ndig, bus.guardar);
         end
      end
      bus.calcstate = 3'b000;
      press(CLR);
      checks++;
      if (bus.op !== '0 || bus.ndig !== '0 || bus.guardar !== 1'b0 || bus.reject !== 1'b0) begin
         errors++;
         $display("FAIL clear: got op=%h ndig=%0d g=%0b rej=%0b, expected all 0",
                  bus.op, bus.ndig, bus.guardar, bus.reject);
      end
   endtask

   task automatic test_back_to_back;
      for (int r = 0; r < 6; r++) begin
         logic [W-1:0] model;
         model = '0;
         @(negedge clk);
         for (int i = 0; i < N; i++) begin
            logic [3:0] d;
            d = 4'($urandom_range(0, 15));
            bus.bc  = 1'b1;
            bus.val = {1'b0, d};
            model   = {model[W-5:0], d};
            @(negedge clk);
            checks++;
            if (bus.op !== model || bus.ndig !== 3'(i + 1)) begin
               errors++;
               $display("FAIL b2b_digit r%0d i%0d: got op=%h ndig=%0d, expected op=%h ndig=%0d",
                        r, i, bus.op, bus.ndig, model, i + 1);
            end
         end
         exp_q.push_back({1'b0, model});
         bus.val = ENTER;
         @(negedge clk);
         bus.bc = 1'b0;
         checks++;
         if (bus.guardar !== 1'b1 || bus.op !== '0) begin
            errors++;
            $display("FAIL b2b_enter r%0d: got g=%0b op=%h, expected g=1 op=0", r, bus.guardar, bus.op);
         end
      end
      // Empty entry commits zero.
      exp_q.push_back('0);
      press(ENTER);
   endtask

   task automatic test_reset_mid;
      press(5'h4); press(5'h2);
      checks++;
      if (bus.op !== 16'h0042) begin
         errors++;
         $display("FAIL mid_setup: got op=%h, expected 0042", bus.op);
      end
      exp_q.push_back({1'b1, 16'h0055});
      bus.calcstate = 3'b010;
      press(5'h15 + 5'h0);  // CLR in OP_STATE keeps the digits cleared path separate
      press(5'h4); // rejected digit
      bus.calcstate = 3'b000;
      press(5'h4); press(5'h2);
      bus.calcstate = 3'b010;
      press(5'h15);
      press(5'h1F);
      exp_q.delete();
      exp_q.push_back({1'b1, 16'h001F});
      press(ENTER);
      bus.calcstate = 3'b000;
      press(5'h4); press(5'h2);
      @(negedge clk);
      reset = 1'b1; bus.bc = 1'b1; bus.val = ENTER;
      @(negedge clk);
      checks++;
      if ({bus.op, bus.ndig, bus.full, bus.guardar, bus.op_saved, bus.is_oper, bus.reject} !== '0) begin
         errors++;
         $display("FAIL reset_mid: got op=%h ndig=%0d g=%0b saved=%h io=%0b rej=%0b, expected all 0",
                  bus.op, bus.ndig, bus.guardar, bus.op_saved, bus.is_oper, bus.reject);
      end
      reset = 1'b0; bus.bc = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_hex_entry();
      test_full_bksp();
      test_dec_mode();
      test_operator();
      test_lock_clear();
      test_back_to_back();
      test_reset_mid();
      repeat (2) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL commits_missing: got %0d unmatched expected commits, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
